// File: rtl/dmem_port_arbiter.sv
// Serialises the two memory requests of a dual-issue packet onto one data-memory port,
// slot 1 first, with a per-access acknowledge timeout.
module dmem_port_arbiter #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iIssue,
    input  logic              iReq1,
    input  logic              iReq2,
    input  logic              iRW1,
    input  logic              iRW2,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [ADDR_W-1:0] iAddr2,
    input  logic [DATA_W-1:0] iWData1,
    input  logic [DATA_W-1:0] iWData2,
    output logic [DATA_W-1:0] oRData1,
    output logic [DATA_W-1:0] oRData2,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic              oMemEn,
    output logic              oMemRW,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    input  logic              iMemAck
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              req2_q;
    logic              rw1_q;
    logic              rw2_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [DATA_W-1:0] wdata1_q;
    logic [DATA_W-1:0] wdata2_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              accept_c;
    logic              in_acc_c;
    logic              timeout_c;
    logic              acc_end_c;
    logic              nxt_rw_c;
    logic [ADDR_W-1:0] nxt_addr_c;
    logic [DATA_W-1:0] nxt_wdata_c;

    assign accept_c  = (state == IDLE) && iIssue && (iReq1 || iReq2);
    assign in_acc_c  = (state == ACC1) || (state == ACC2);
    // The last allowed wait cycle without an ack aborts the access.
    assign timeout_c = in_acc_c && !iMemAck && (wait_cnt == CNT_LAST);
    assign acc_end_c = in_acc_c && (iMemAck || timeout_c);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_c) state_nxt = iReq1 ? ACC1 : ACC2;
            ACC1: if (acc_end_c) state_nxt = req2_q ? ACC2 : DONE;
            ACC2: if (acc_end_c) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory command for the upcoming cycle; slot fields come straight from the inputs on issue
    always_comb begin
        nxt_rw_c    = 1'b0;
        nxt_addr_c  = '0;
        nxt_wdata_c = '0;
        if (state_nxt == ACC1) begin
            nxt_rw_c    = (state == IDLE) ? iRW1    : rw1_q;
            nxt_addr_c  = (state == IDLE) ? iAddr1  : addr1_q;
            nxt_wdata_c = (state == IDLE) ? iWData1 : wdata1_q;
        end else if (state_nxt == ACC2) begin
            nxt_rw_c    = (state == IDLE) ? iRW2    : rw2_q;
            nxt_addr_c  = (state == IDLE) ? iAddr2  : addr2_q;
            nxt_wdata_c = (state == IDLE) ? iWData2 : wdata2_q;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Slot field latch
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            req2_q   <= 1'b0;
            rw1_q    <= 1'b0;
            rw2_q    <= 1'b0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
        end else if (accept_c) begin
            req2_q   <= iReq2;
            rw1_q    <= iRW1;
            rw2_q    <= iRW2;
            addr1_q  <= iAddr1;
            addr2_q  <= iAddr2;
            wdata1_q <= iWData1;
            wdata2_q <= iWData2;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset)                     wait_cnt <= '0;
        else if (!in_acc_c || acc_end_c) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // Load data and error flag; cleared when a packet is accepted
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            oRData1 <= '0;
            oRData2 <= '0;
            oErr    <= 1'b0;
        end else if (accept_c) begin
            oRData1 <= '0;
            oRData2 <= '0;
            oErr    <= 1'b0;
        end else if (acc_end_c && (state == ACC1)) begin
            if (timeout_c) begin
                oRData1 <= '0;
                oErr    <= 1'b1;
            end else if (!rw1_q) begin
                oRData1 <= iMemRData;
            end
        end else if (acc_end_c && (state == ACC2)) begin
            if (timeout_c) begin
                oRData2 <= '0;
                oErr    <= 1'b1;
            end else if (!rw2_q) begin
                oRData2 <= iMemRData;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oMemEn    <= 1'b0;
            oMemRW    <= 1'b0;
            oMemAddr  <= '0;
            oMemWData <= '0;
        end else begin
            oBusy     <= (state_nxt != IDLE);
            oDone     <= (state_nxt == DONE);
            oMemEn    <= (state_nxt == ACC1) || (state_nxt == ACC2);
            oMemRW    <= nxt_rw_c;
            oMemAddr  <= nxt_addr_c;
            oMemWData <= nxt_wdata_c;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised scoreboard bench for dmem_port_arbiter: a behavioural memory with
// configurable wait states plus a program-order RAM reference model.
module tb_dmem_port_arbiter;

    localparam int T = 4;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iIssue = 1'b0;
    logic        iReq1 = 1'b0, iReq2 = 1'b0, iRW1 = 1'b0, iRW2 = 1'b0;
    logic [15:0] iAddr1 = '0, iAddr2 = '0, iWData1 = '0, iWData2 = '0;
    logic [15:0] oRData1, oRData2, oMemAddr, oMemWData;
    logic        oBusy, oDone, oErr, oMemEn, oMemRW;
    logic [15:0] iMemRData = '0;
    logic        iMemAck = 1'b0;

    dmem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .ACK_TIMEOUT(T)) dut (
        .iClock(iClock), .iReset(iReset), .iIssue(iIssue),
        .iReq1(iReq1), .iReq2(iReq2), .iRW1(iRW1), .iRW2(iRW2),
        .iAddr1(iAddr1), .iAddr2(iAddr2), .iWData1(iWData1), .iWData2(iWData2),
        .oRData1(oRData1), .oRData2(oRData2), .oBusy(oBusy), .oDone(oDone), .oErr(oErr),
        .oMemEn(oMemEn), .oMemRW(oMemRW), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
        .iMemRData(iMemRData), .iMemAck(iMemAck)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        err;
        int          lat;
        int          issue;
    } pkt_t;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wd;
        int          wt;
    } acc_t;

    pkt_t exp_pkt_q[$];
    acc_t exp_acc_q[$];
    logic [15:0] mem     [logic [15:0]];
    logic [15:0] ref_ram [logic [15:0]];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge iClock) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural memory: acks after the wait count of the expected access, never if it exceeds T-1
    int          wcnt = 0;
    bit          cur_valid = 0;
    int          cur_wait = 0;
    acc_t        cur;
    logic        prev_en = 0, prev_ack = 0, prev_rw = 0;
    logic [15:0] prev_addr = '0, prev_wd = '0;

    always @(negedge iClock) begin
        if (!iReset) begin
            wcnt = 0; cur_valid = 0; prev_en = 0; prev_ack = 0;
            iMemAck = 0; iMemRData = '0;
        end else begin
            if (prev_en) begin
                if (prev_ack) begin
                    if (prev_rw) mem[prev_addr] = prev_wd;
                    wcnt = 0; cur_valid = 0;
                end else if (wcnt + 1 >= T) begin
                    wcnt = 0; cur_valid = 0;
                end else begin
                    wcnt++;
                end
            end
            iMemAck = 0;
            iMemRData = '0;
            if (oMemEn) begin
                if (!cur_valid) begin
                    if (exp_acc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_access: got addr %0h expected none (cycle %0d)", oMemAddr, cyc);
                        cur.rw = oMemRW; cur.addr = oMemAddr; cur.wd = oMemWData; cur.wt = 0;
                    end else begin
                        cur = exp_acc_q.pop_front();
                        chk("acc_rw", 32'(oMemRW), 32'(cur.rw));
                        chk("acc_addr", 32'(oMemAddr), 32'(cur.addr));
                        if (cur.rw) chk("acc_wdata", 32'(oMemWData), 32'(cur.wd));
                    end
                    cur_wait = cur.wt;
                    cur_valid = 1;
                end else begin
                    chk("acc_steady", {15'd0, oMemRW, oMemAddr}, {15'd0, cur.rw, cur.addr});
                end
                if (cur_wait < T && wcnt >= cur_wait) begin
                    iMemAck = 1;
                    iMemRData = mem.exists(oMemAddr) ? mem[oMemAddr] : init_val(oMemAddr);
                end
            end
            prev_en = oMemEn; prev_ack = iMemAck; prev_rw = oMemRW;
            prev_addr = oMemAddr; prev_wd = oMemWData;
        end
    end

    // Packet monitor
    always @(negedge iClock) begin
        if (iReset) begin
            if (oMemEn && !oBusy) chk("en_without_busy", 32'(oBusy), 32'd1);
            if (oDone) begin
                if (exp_pkt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got oDone=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    pkt_t e;
                    e = exp_pkt_q.pop_front();
                    chk("rdata1", 32'(oRData1), 32'(e.d1));
                    chk("rdata2", 32'(oRData2), 32'(e.d2));
                    chk("err", 32'(oErr), 32'(e.err));
                    chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    chk("busy_at_done", 32'(oBusy), 32'd1);
                end
            end
        end
    end

    // Reference model: apply the slots in program order; a timed-out slot yields 0 and no write
    task automatic start_pkt(input bit r1, r2, w1rw, w2rw, input logic [15:0] a1, a2, d1, d2,
                             input int wt1, wt2);
        pkt_t e;
        acc_t a;
        e.d1 = '0; e.d2 = '0; e.err = 0; e.lat = 0;
        iReq1 = r1; iReq2 = r2; iRW1 = w1rw; iRW2 = w2rw;
        iAddr1 = a1; iAddr2 = a2; iWData1 = d1; iWData2 = d2;
        iIssue = 1;
        if (r1) begin
            a.rw = w1rw; a.addr = a1; a.wd = d1; a.wt = wt1; exp_acc_q.push_back(a);
            if (wt1 >= T) begin e.err = 1; e.lat += T; end
            else begin
                e.lat += wt1 + 1;
                if (w1rw) ref_ram[a1] = d1; else e.d1 = ref_rd(a1);
            end
        end
        if (r2) begin
            a.rw = w2rw; a.addr = a2; a.wd = d2; a.wt = wt2; exp_acc_q.push_back(a);
            if (wt2 >= T) begin e.err = 1; e.lat += T; end
            else begin
                e.lat += wt2 + 1;
                if (w2rw) ref_ram[a2] = d2; else e.d2 = ref_rd(a2);
            end
        end
        e.issue = cyc + 1;
        if (r1 || r2) exp_pkt_q.push_back(e);
        @(negedge iClock);
        iIssue = 0;
    endtask

    task automatic finish_pkt(input bit poke_done);
        int n = 0;
        while (!oDone && n < 200) begin
            @(negedge iClock);
            n++;
        end
        if (!oDone) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no oDone expected oDone within 200 cycles");
        end
        if (poke_done) begin
            iIssue = 1; iReq1 = 1;
        end
        @(negedge iClock);
        iIssue = 0;
        chk("idle_after_done", {30'd0, oBusy, oMemEn}, 32'd0);
    endtask

    task automatic run_pkt(input bit r1, r2, w1rw, w2rw, input logic [15:0] a1, a2, d1, d2,
                           input int wt1, wt2, input bit poke_done);
        start_pkt(r1, r2, w1rw, w2rw, a1, a2, d1, d2, wt1, wt2);
        if (r1 || r2) finish_pkt(poke_done);
        else begin
            repeat (3) begin
                chk("noreq_idle", {29'd0, oBusy, oMemEn, oDone}, 32'd0);
                @(negedge iClock);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge iClock);
        chk("reset_outputs", {oBusy, oDone, oErr, oMemEn, oMemRW, 11'd0, oRData1}, 32'd0);
        chk("reset_rdata2", 32'(oRData2), 32'd0);
        iReset = 1;
        @(negedge iClock);

        mem[16'h0010] = 16'hBEEF; ref_ram[16'h0010] = 16'hBEEF;
        run_pkt(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        run_pkt(1, 1, 1, 0, 16'h0020, 16'h0020, 16'h1234, 16'h0000, 0, 0, 1);
        run_pkt(0, 1, 0, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 3, 0);
        run_pkt(1, 1, 0, 0, 16'h0007, 16'h0020, 16'h0000, 16'h0000, 99, 1, 0);
        run_pkt(1, 1, 1, 1, 16'h0030, 16'h0030, 16'hAAAA, 16'h5555, 0, 2, 0);
        run_pkt(1, 0, 0, 0, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        run_pkt(0, 0, 1, 1, 16'h0040, 16'h0041, 16'h1111, 16'h2222, 0, 0, 0);

        // Reset while slot 2 waits for an ack
        start_pkt(1, 1, 0, 0, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 0, 99);
        begin
            int n = 0;
            while (!(oMemEn && oMemAddr == 16'h0005) && n < 50) begin
                @(negedge iClock);
                n++;
            end
        end
        chk("reached_acc2", {15'd0, oMemEn, oMemAddr}, {15'd0, 1'b1, 16'h0005});
        @(posedge iClock);
        #2;
        iReset = 0;
        #1;
        chk("rst_mid_ctrl", {29'd0, oMemEn, oBusy, oDone}, 32'd0);
        chk("rst_mid_data", {15'd0, oErr, oRData1}, 32'd0);
        exp_pkt_q.delete();
        exp_acc_q.delete();
        repeat (2) @(negedge iClock);
        iReset = 1;
        @(negedge iClock);
        run_pkt(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int w1 = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
            int w2 = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
            run_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)),
                    16'($urandom), 16'($urandom), w1, w2, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge iClock);
        chk("pkt_queue_empty", 32'(exp_pkt_q.size()), 32'd0);
        chk("acc_queue_empty", 32'(exp_acc_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
